// File: rtl/detector_jogada_pkg.sv
// ============================================================================
// Module   : detector_jogada_pkg
// Purpose  : Shared definitions for the play detector: FSM state encoding,
//            debounce default and a one-hot helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package detector_jogada_pkg;

    // Default number of stable samples needed to accept a press or release
    localparam int unsigned c_debounce_ciclos_padrao = 50000;

    // Width of the push-button bus
    localparam int unsigned c_largura_botoes = 4;

    // FSM state codes; kept 4 bits wide so they can drive a hex display directly
    typedef enum logic [3:0] {
        OCIOSO      = 4'd0,
        FILTRANDO   = 4'd1,
        PRESSIONADO = 4'd2,
        SOLTANDO    = 4'd3
    } estado_t;

    // True when exactly one bit of the button pattern is set
    function automatic logic eh_one_hot(input logic [c_largura_botoes-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sincronizador_2ff.sv
// ============================================================================
// Module   : sincronizador_2ff
// Purpose  : Two-flop synchronizer bringing asynchronous levels into the
//            clock domain. Each bit is synchronized independently.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sincronizador_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_dado,
    output logic [WIDTH-1:0] o_dado
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sinc;

    // First flop may go metastable; second flop gives it a full cycle to settle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_meta <= '0;
            r_sinc <= '0;
        end else begin
            r_meta <= i_dado;
            r_sinc <= r_meta;
        end
    end

    assign o_dado = r_sinc;

endmodule

`default_nettype wire

// File: rtl/detector_jogada.sv
// ============================================================================
// Module   : detector_jogada
// Purpose  : Debounces four push buttons and reports accepted plays. A press
//            must be stable for DEBOUNCE_CICLOS samples to be accepted and
//            a release must be equally stable before a new play is possible.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module detector_jogada
    import detector_jogada_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CICLOS = c_debounce_ciclos_padrao
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       habilita,
    output logic [3:0] jogada,
    output logic       jogada_valida,
    output logic       jogada_invalida,
    output logic       db_tem_jogada,
    output logic [3:0] db_estado
);

    // Counter only ever reaches DEBOUNCE_CICLOS-1, so clog2 bits are enough
    localparam int unsigned c_largura_cont =
        (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [c_largura_cont-1:0] c_cont_max = c_largura_cont'(DEBOUNCE_CICLOS - 1);
    localparam logic [c_largura_cont-1:0] c_cont_um  = c_largura_cont'(1);

    logic [3:0]                w_botoes_s;
    estado_t                   r_estado;
    logic [3:0]                r_candidato;
    logic [c_largura_cont-1:0] r_contador;
    logic [3:0]                r_jogada;
    logic                      r_valida;
    logic                      r_invalida;

    // Raw buttons are only ever seen through the synchronizer
    sincronizador_2ff #(
        .WIDTH (c_largura_botoes)
    ) u_sincronizador (
        .clock  (clock),
        .reset  (reset),
        .i_dado (botoes),
        .o_dado (w_botoes_s)
    );

    // Debounce FSM; pulses default low and are set only on the accept edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado    <= OCIOSO;
            r_candidato <= '0;
            r_contador  <= '0;
            r_jogada    <= '0;
            r_valida    <= 1'b0;
            r_invalida  <= 1'b0;
        end else begin
            r_valida   <= 1'b0;
            r_invalida <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (w_botoes_s != '0) begin
                        r_candidato <= w_botoes_s;
                        r_contador  <= '0;
                        r_estado    <= FILTRANDO;
                    end
                end
                FILTRANDO: begin
                    if (w_botoes_s != r_candidato) begin
                        // Pattern changed while filtering: treat as bounce
                        r_estado <= OCIOSO;
                    end else if (r_contador == c_cont_max) begin
                        r_estado <= PRESSIONADO;
                        if (!eh_one_hot(r_candidato)) begin
                            r_invalida <= 1'b1;
                        end else if (habilita) begin
                            r_jogada <= r_candidato;
                            r_valida <= 1'b1;
                        end
                    end else begin
                        r_contador <= r_contador + c_cont_um;
                    end
                end
                PRESSIONADO: begin
                    // Any nonzero pattern keeps the press alive
                    if (w_botoes_s == '0) begin
                        r_contador <= '0;
                        r_estado   <= SOLTANDO;
                    end
                end
                SOLTANDO: begin
                    if (w_botoes_s != '0) begin
                        r_estado <= PRESSIONADO;
                    end else if (r_contador == c_cont_max) begin
                        r_estado <= OCIOSO;
                    end else begin
                        r_contador <= r_contador + c_cont_um;
                    end
                end
                default: begin
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

    assign jogada          = r_jogada;
    assign jogada_valida   = r_valida;
    assign jogada_invalida = r_invalida;
    assign db_tem_jogada   = (r_estado == PRESSIONADO);
    assign db_estado       = r_estado;

endmodule

`default_nettype wire

// File: tb/tb_detector_jogada.sv
// ============================================================================
// Module   : tb_detector_jogada
// Purpose  : Directed self-checking bench for detector_jogada with a short
//            debounce window (4 samples).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_detector_jogada;

    localparam int unsigned c_debounce = 4;

    logic       clock;
    logic       reset;
    logic [3:0] botoes;
    logic       habilita;
    logic [3:0] jogada;
    logic       jogada_valida;
    logic       jogada_invalida;
    logic       db_tem_jogada;
    logic [3:0] db_estado;

    int n_checks = 0;
    int n_falhas = 0;

    detector_jogada #(
        .DEBOUNCE_CICLOS (c_debounce)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .botoes          (botoes),
        .habilita        (habilita),
        .jogada          (jogada),
        .jogada_valida   (jogada_valida),
        .jogada_invalida (jogada_invalida),
        .db_tem_jogada   (db_tem_jogada),
        .db_estado       (db_estado)
    );

    // 100 MHz clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
        n_checks++;
        if (obtido !== esperado) begin
            n_falhas++;
            $display("FAIL %s: obtido=%0h esperado=%0h", tag, obtido, esperado);
        end
    endtask

    // Runs n edges; each sample is taken 1 ns after the edge, index k = edge k
    task automatic roda_ciclos(input int n, output int n_val, output int n_inv,
                               output int pri_val, output int pri_inv, output int n_ambos);
        n_val = 0; n_inv = 0; pri_val = -1; pri_inv = -1; n_ambos = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            if (jogada_valida === 1'b1) begin
                n_val++;
                if (pri_val < 0) pri_val = k;
            end
            if (jogada_invalida === 1'b1) begin
                n_inv++;
                if (pri_inv < 0) pri_inv = k;
            end
            if (jogada_valida === 1'b1 && jogada_invalida === 1'b1) n_ambos++;
        end
    endtask

    int nv, ni, pv, pi, na;
    int tot_v, tot_i, tot_a;

    initial begin
        reset    = 1'b0;
        botoes   = 4'b0000;
        habilita = 1'b1;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        verifica("rst_jogada",   32'(jogada), 32'h0);
        verifica("rst_valida",   32'(jogada_valida), 32'h0);
        verifica("rst_invalida", 32'(jogada_invalida), 32'h0);
        verifica("rst_tem",      32'(db_tem_jogada), 32'h0);
        verifica("rst_estado",   32'(db_estado), 32'h0);
        reset = 1'b1;
        roda_ciclos(3, nv, ni, pv, pi, na);
        verifica("idle_estado", 32'(db_estado), 32'h0);

        // Valid press 0010: pulse right after edge 6 only
        botoes = 4'b0010;
        roda_ciclos(20, nv, ni, pv, pi, na);
        verifica("t1_n_valida",  32'(nv), 32'd1);
        verifica("t1_pri_valida", 32'(pv), 32'd6);
        verifica("t1_n_invalida", 32'(ni), 32'd0);
        verifica("t1_jogada",    32'(jogada), 32'h2);
        verifica("t1_tem",       32'(db_tem_jogada), 32'h1);
        verifica("t1_estado",    32'(db_estado), 32'h2);
        botoes = 4'b0000;
        roda_ciclos(3, nv, ni, pv, pi, na);
        verifica("t1_soltando", 32'(db_estado), 32'h3);
        roda_ciclos(7, nv, ni, pv, pi, na);
        verifica("t1_rel_estado", 32'(db_estado), 32'h0);
        verifica("t1_rel_pulsos", 32'(nv + ni), 32'd0);

        // Bouncing 0100 never settles long enough
        tot_v = 0; tot_i = 0;
        for (int j = 0; j < 10; j++) begin
            botoes = (j % 2 == 0) ? 4'b0100 : 4'b0000;
            roda_ciclos(2, nv, ni, pv, pi, na);
            tot_v += nv; tot_i += ni;
        end
        botoes = 4'b0000;
        roda_ciclos(10, nv, ni, pv, pi, na);
        tot_v += nv; tot_i += ni;
        verifica("t2_n_valida",   32'(tot_v), 32'd0);
        verifica("t2_n_invalida", 32'(tot_i), 32'd0);
        verifica("t2_jogada",     32'(jogada), 32'h2);
        verifica("t2_estado",     32'(db_estado), 32'h0);

        // Two buttons at once: invalid pulse, jogada kept
        botoes = 4'b0011;
        roda_ciclos(20, nv, ni, pv, pi, na);
        verifica("t3_n_invalida",  32'(ni), 32'd1);
        verifica("t3_pri_invalida", 32'(pi), 32'd6);
        verifica("t3_n_valida",    32'(nv), 32'd0);
        verifica("t3_ambos",       32'(na), 32'd0);
        verifica("t3_jogada",      32'(jogada), 32'h2);
        botoes = 4'b0000;
        roda_ciclos(10, nv, ni, pv, pi, na);

        // Disabled acceptance: press held, no pulse, FSM still reaches PRESSIONADO
        habilita = 1'b0;
        botoes   = 4'b1000;
        roda_ciclos(20, nv, ni, pv, pi, na);
        verifica("t4_n_pulsos", 32'(nv + ni), 32'd0);
        verifica("t4_tem",      32'(db_tem_jogada), 32'h1);
        verifica("t4_jogada",   32'(jogada), 32'h2);
        botoes = 4'b0000;
        roda_ciclos(10, nv, ni, pv, pi, na);
        habilita = 1'b1;
        verifica("t4_rel_pulsos", 32'(nv + ni), 32'd0);
        botoes = 4'b0001;
        roda_ciclos(20, nv, ni, pv, pi, na);
        verifica("t4b_n_valida",  32'(nv), 32'd1);
        verifica("t4b_pri_valida", 32'(pv), 32'd6);
        verifica("t4b_jogada",    32'(jogada), 32'h1);
        botoes = 4'b0000;
        roda_ciclos(10, nv, ni, pv, pi, na);

        // Short release glitch while pressed must not allow a second play
        tot_v = 0; tot_i = 0; tot_a = 0;
        botoes = 4'b0001;
        roda_ciclos(10, nv, ni, pv, pi, na);
        tot_v += nv; tot_i += ni; tot_a += na;
        botoes = 4'b0000;
        roda_ciclos(2, nv, ni, pv, pi, na);
        tot_v += nv; tot_i += ni; tot_a += na;
        botoes = 4'b0001;
        roda_ciclos(10, nv, ni, pv, pi, na);
        tot_v += nv; tot_i += ni; tot_a += na;
        verifica("t5_estado_glitch", 32'(db_estado), 32'h2);
        botoes = 4'b0000;
        roda_ciclos(10, nv, ni, pv, pi, na);
        tot_v += nv; tot_i += ni; tot_a += na;
        verifica("t5_n_valida",   32'(tot_v), 32'd1);
        verifica("t5_n_invalida", 32'(tot_i), 32'd0);
        verifica("t5_ambos",      32'(tot_a), 32'd0);
        verifica("t5_estado",     32'(db_estado), 32'h0);

        // Asynchronous reset mid-press, button still held afterwards
        botoes = 4'b0100;
        roda_ciclos(10, nv, ni, pv, pi, na);
        verifica("t6_jogada_pre", 32'(jogada), 32'h4);
        verifica("t6_tem_pre",    32'(db_tem_jogada), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        verifica("t6_rst_jogada", 32'(jogada), 32'h0);
        verifica("t6_rst_tem",    32'(db_tem_jogada), 32'h0);
        verifica("t6_rst_estado", 32'(db_estado), 32'h0);
        verifica("t6_rst_pulsos", 32'({jogada_valida, jogada_invalida}), 32'h0);
        roda_ciclos(2, nv, ni, pv, pi, na);
        verifica("t6_rst_hold", 32'(nv + ni), 32'd0);
        reset = 1'b1;
        roda_ciclos(12, nv, ni, pv, pi, na);
        verifica("t6_n_valida",   32'(nv), 32'd1);
        verifica("t6_pri_valida", 32'(pv), 32'd6);
        verifica("t6_jogada",     32'(jogada), 32'h4);
        botoes = 4'b0000;
        roda_ciclos(10, nv, ni, pv, pi, na);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_falhas);
        $finish;
    end

endmodule

`default_nettype wire
